// File: rtl/output_port_writer.sv
// output_port_writer: drives the 16-bit OUTPUT port from a small write FIFO.
// Each OUT write from the core is queued. It is then presented on OUTPUT for
// at least HOLD cycles, so an external observer sees every write as a
// separate event.
// Optional feature macro: OUTPUT_STROBE_EN adds the out_stb port. out_stb is
// a one-cycle pulse after every OUTPUT load.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | nothing on hold; pop the FIFO head as soon as one is queued
// S_HOLD | OUTPUT is being held; hold_q counts down the remaining cycles
module output_port_writer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int HOLD   = 2
) (
  input  logic              ClK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              overflow,
`ifdef OUTPUT_STROBE_EN
  output logic              out_stb,
`endif
  output logic [DATA_W-1:0] OUTPUT
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [HW-1:0]     hold_q;
  logic [DATA_W-1:0] out_q;
  logic              ovf_q;
  state_t            state_q;
  logic              pop, push, drop;

  // Pop whenever the hold window has expired and data is queued.
  // A push is allowed into a full FIFO only when a pop happens on the same edge.
  always_comb begin
    pop     = (count_q != '0) && ((state_q == S_IDLE) || (hold_q == '0));
    push    = wr_en && ((count_q < DEPTH_C) || pop);
    drop    = wr_en && !push;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // FIFO storage; entries are only read after being written, so no reset is needed.
  always_ff @(posedge ClK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge ClK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Output sequencer: load OUTPUT from the FIFO head and enforce the hold time.
  always_ff @(posedge ClK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            out_q   <= mem_q[rd_ptr_q];
            hold_q  <= HOLD_INIT;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else if (count_q != '0) begin
            out_q  <= mem_q[rd_ptr_q];
            hold_q <= HOLD_INIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_STROBE_EN
  logic stb_q;

  // One-cycle strobe after every load, so repeated identical values stay visible.
  always_ff @(posedge ClK or negedge RESET) begin
    if (!RESET) stb_q <= 1'b0;
    else        stb_q <= pop;
  end

  assign out_stb = stb_q;
`endif

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE) || (count_q != '0);
  assign overflow = ovf_q;
  assign OUTPUT   = out_q;

endmodule
